mult_cell_arbiter: RTL and testbench

Round-robin arbiter and sequencer sharing one 16x16 partial-product multiply cell among NUM_REQ requesters. It issues one 32x32 multiply per cycle and drives the cell's operands and enable. It combines the cell's three registered partial products into the low 32 bits of the product and returns the result tagged with the requester index. It sits between the per-core multiply requesters and the multiply cell in the parallel CPU subsystem.

---
 rtl/mult_cell_arbiter.sv | 148 ++++++++++++++
 tb/tb_mult_cell_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_cell_arbiter.sv
// mult_cell_arbiter
// Round-robin arbiter and sequencer that shares one 16x16 partial-product
// multiply cell among NUM_REQ requesters. It issues at most one 32x32 multiply
// per cycle and folds the cell's three partial products into the low product
// word, tagged with the index of the requester that issued the op.
// Pipeline: A (operands/tag, drives the cell) -> M (inside the cell) -> C (result).
module mult_cell_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  hold,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [32*NUM_REQ-1:0] req_src1,
    input  logic [32*NUM_REQ-1:0] req_src2,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [31:0]           mul_src1,
    output logic [31:0]           mul_src2,
    output logic                  mul_en,
    input  logic [31:0]           mul_p1,
    input  logic [31:0]           mul_p2,
    input  logic [31:0]           mul_p3,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_result,
    output logic                  busy
);

    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] grant_idx;
    logic            grant_found;
    logic [31:0]     sel_src1;
    logic [31:0]     sel_src2;

    logic            a_valid;
    logic [ID_W-1:0] a_tag;
    logic [31:0]     a_src1;
    logic [31:0]     a_src2;

    logic            m_valid;
    logic [ID_W-1:0] m_tag;

    logic            c_valid;
    logic [ID_W-1:0] c_tag;
    logic [31:0]     c_result;

    logic [15:0]     cross_lo;
    logic [31:0]     combined;
    logic            unused_hi;

    // Round-robin search starting just after the last granted requester; no grant while held or in reset
    always_comb begin
        req_ready   = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        sel_src1    = '0;
        sel_src2    = '0;
        if (!hold && reset_n) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
                if (!grant_found && req_valid[cand]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
        if (grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_src1 = req_src1[32*i +: 32];
                sel_src2 = req_src2[32*i +: 32];
            end
        end
    end

    // Pointer moves only on a handshake, so an idle or withdrawn requester never costs anyone a turn
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= ID_W'(NUM_REQ - 1);
        end else if (grant_found) begin
            last_grant <= grant_idx;
        end
    end

    // Stage A captures the granted operands and tag; they feed the cell directly
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_valid <= 1'b0;
            a_tag   <= '0;
            a_src1  <= '0;
            a_src2  <= '0;
        end else if (!hold) begin
            a_valid <= grant_found;
            if (grant_found) begin
                a_tag  <= grant_idx;
                a_src1 <= sel_src1;
                a_src2 <= sel_src2;
            end
        end
    end

    // Stage M only tracks validity and tag; the products themselves live in the cell
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid <= 1'b0;
            m_tag   <= '0;
        end else if (!hold) begin
            m_valid <= a_valid;
            m_tag   <= a_tag;
        end
    end

    // Only the low half of p2+p3 lands inside the low product word
    always_comb begin
        cross_lo  = mul_p2[15:0] + mul_p3[15:0];
        combined  = mul_p1 + {cross_lo, 16'h0000};
        unused_hi = ^{mul_p2[31:16], mul_p3[31:16]};
    end

    // Stage C registers the combined result while the cell products are valid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_valid  <= 1'b0;
            c_tag    <= '0;
            c_result <= '0;
        end else if (!hold) begin
            c_valid <= m_valid;
            if (m_valid) begin
                c_tag    <= m_tag;
                c_result <= combined;
            end
        end
    end

    assign mul_src1   = a_src1;
    assign mul_src2   = a_src2;
    assign mul_en     = a_valid & ~hold;
    assign rsp_valid  = c_valid & ~hold;
    assign rsp_id     = c_tag;
    assign rsp_result = c_result;
    assign busy       = a_valid | m_valid | c_valid;

endmodule

// File: tb/tb_mult_cell_arbiter.sv
// tb_mult_cell_arbiter
// Directed bench for mult_cell_arbiter with a behavioural model of the
// registered 16x16 partial-product cell and a queue of hand-computed responses.
module tb_mult_cell_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk;
    logic                  reset_n;
    logic                  hold;
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_src1;
    logic [32*NUM_REQ-1:0] req_src2;
    logic [NUM_REQ-1:0]    req_ready;
    logic [31:0]           mul_src1;
    logic [31:0]           mul_src2;
    logic                  mul_en;
    logic [31:0]           mul_p1;
    logic [31:0]           mul_p2;
    logic [31:0]           mul_p3;
    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_result;
    logic                  busy;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [31:0]     res;
    } exp_t;

    exp_t expQueue[$];
    int   compared;
    int   mismatched;

    // Hand-computed low product words for the operands loaded into each requester
    logic [31:0] opA [NUM_REQ];
    logic [31:0] opB [NUM_REQ];
    logic [31:0] expRes [NUM_REQ];

    mult_cell_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .hold      (hold),
        .req_valid (req_valid),
        .req_src1  (req_src1),
        .req_src2  (req_src2),
        .req_ready (req_ready),
        .mul_src1  (mul_src1),
        .mul_src2  (mul_src2),
        .mul_en    (mul_en),
        .mul_p1    (mul_p1),
        .mul_p2    (mul_p2),
        .mul_p3    (mul_p3),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_result(rsp_result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural cell: registers partial products on enable, cleared by the shared reset
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mul_p1 <= '0;
            mul_p2 <= '0;
            mul_p3 <= '0;
        end else if (mul_en) begin
            mul_p1 <= mul_src1[15:0]  * mul_src2[15:0];
            mul_p2 <= mul_src1[15:0]  * mul_src2[31:16];
            mul_p3 <= mul_src1[31:16] * mul_src2[15:0];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic hold_v);
        req_valid = valid;
        hold      = hold_v;
        #1;
    endtask

    task automatic setOperands(input int idx, input logic [31:0] a, input logic [31:0] b);
        req_src1[32*idx +: 32] = a;
        req_src2[32*idx +: 32] = b;
    endtask

    task automatic expectRsp(input logic [ID_W-1:0] id, input logic [31:0] res);
        exp_t e;
        e.id  = id;
        e.res = res;
        expQueue.push_back(e);
    endtask

    // Every response is matched in order against the queue of expected results
    always @(negedge clk) begin
        if (reset_n && rsp_valid) begin
            if (expQueue.size() == 0) begin
                checkOutput("rsp_unexpected", {30'd0, rsp_id}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = expQueue.pop_front();
                checkOutput("rsp_id", {30'd0, rsp_id}, {30'd0, e.id});
                checkOutput("rsp_result", rsp_result, e.res);
            end
        end
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        opA[0] = 32'h0000_FFFF; opB[0] = 32'h0000_FFFF; expRes[0] = 32'hFFFE_0001;
        opA[1] = 32'h0001_0003; opB[1] = 32'h0000_0100; expRes[1] = 32'h0100_0300;
        opA[2] = 32'h1234_5678; opB[2] = 32'h0001_0001; expRes[2] = 32'h68AC_5678;
        opA[3] = 32'hFFFF_FFFF; opB[3] = 32'hFFFF_FFFF; expRes[3] = 32'h0000_0001;

        // Reset state, with requests pending to show that nothing is granted in reset
        reset_n   = 1'b0;
        req_src1  = '0;
        req_src2  = '0;
        applyStimulus(4'b1111, 1'b0);
        checkOutput("reset_req_ready", {28'd0, req_ready}, 32'h0);
        checkOutput("reset_busy", {31'd0, busy}, 32'h0);
        checkOutput("reset_mul_en", {31'd0, mul_en}, 32'h0);
        checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'h0);
        checkOutput("reset_rsp_result", rsp_result, 32'h0);
        checkOutput("reset_mul_src1", mul_src1, 32'h0);
        applyStimulus(4'b0000, 1'b0);
        step();
        step();
        reset_n = 1'b1;
        step();

        // Single op on requester 0: 7 * 6, response three cycles after the handshake
        setOperands(0, 32'd7, 32'd6);
        applyStimulus(4'b0001, 1'b0);
        checkOutput("single_grant", {28'd0, req_ready}, 32'h1);
        expectRsp(2'd0, 32'h0000_002A);
        step();
        applyStimulus(4'b0000, 1'b0);
        checkOutput("single_c1_busy", {31'd0, busy}, 32'h1);
        checkOutput("single_c1_mul_en", {31'd0, mul_en}, 32'h1);
        checkOutput("single_c1_src1", mul_src1, 32'd7);
        checkOutput("single_c1_src2", mul_src2, 32'd6);
        checkOutput("single_c1_rsp", {31'd0, rsp_valid}, 32'h0);
        step();
        checkOutput("single_c2_busy", {31'd0, busy}, 32'h1);
        checkOutput("single_c2_rsp", {31'd0, rsp_valid}, 32'h0);
        step();
        checkOutput("single_c3_rsp", {31'd0, rsp_valid}, 32'h1);
        checkOutput("single_c3_id", {30'd0, rsp_id}, 32'h0);
        checkOutput("single_c3_result", rsp_result, 32'h0000_002A);
        checkOutput("single_c3_busy", {31'd0, busy}, 32'h1);
        step();
        checkOutput("single_c4_rsp", {31'd0, rsp_valid}, 32'h0);
        checkOutput("single_c4_busy", {31'd0, busy}, 32'h0);

        // Fairness: reset the pointer, then all four requesters held for eight cycles
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        for (int i = 0; i < NUM_REQ; i++) setOperands(i, opA[i], opB[i]);
        applyStimulus(4'b1111, 1'b0);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("rr_grant%0d", k), {28'd0, req_ready}, 32'h1 << (k % NUM_REQ));
            expectRsp(ID_W'(k % NUM_REQ), expRes[k % NUM_REQ]);
            step();
        end
        applyStimulus(4'b0000, 1'b0);
        for (int k = 0; k < 5; k++) step();
        checkOutput("rr_drained_busy", {31'd0, busy}, 32'h0);

        // Hold: three ops in flight frozen for two cycles
        applyStimulus(4'b0111, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("hold_grant%0d", k), {28'd0, req_ready}, 32'h1 << k);
            expectRsp(ID_W'(k), expRes[k]);
            step();
        end
        applyStimulus(4'b1111, 1'b1);
        for (int k = 0; k < 2; k++) begin
            checkOutput("hold_req_ready", {28'd0, req_ready}, 32'h0);
            checkOutput("hold_mul_en", {31'd0, mul_en}, 32'h0);
            checkOutput("hold_rsp_valid", {31'd0, rsp_valid}, 32'h0);
            checkOutput("hold_busy", {31'd0, busy}, 32'h1);
            step();
        end
        applyStimulus(4'b0000, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("hold_late_rsp%0d", k), {31'd0, rsp_valid}, 32'h1);
            checkOutput($sformatf("hold_late_id%0d", k), {30'd0, rsp_id}, k);
            step();
        end
        checkOutput("hold_after_rsp", {31'd0, rsp_valid}, 32'h0);
        checkOutput("hold_after_busy", {31'd0, busy}, 32'h0);

        // Reset mid-flight: two handshakes, then reset drops both ops
        applyStimulus(4'b0011, 1'b0);
        checkOutput("rst_grant0", {28'd0, req_ready}, 32'h1);
        step();
        applyStimulus(4'b0010, 1'b0);
        checkOutput("rst_grant1", {28'd0, req_ready}, 32'h2);
        step();
        reset_n = 1'b0;
        applyStimulus(4'b0000, 1'b0);
        checkOutput("rst_async_busy", {31'd0, busy}, 32'h0);
        checkOutput("rst_async_mul_en", {31'd0, mul_en}, 32'h0);
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checkOutput("rst_no_rsp", {31'd0, rsp_valid}, 32'h0);
            checkOutput("rst_no_busy", {31'd0, busy}, 32'h0);
            step();
        end
        applyStimulus(4'b0011, 1'b0);
        checkOutput("rst_restart_grant", {28'd0, req_ready}, 32'h1);
        expectRsp(2'd0, expRes[0]);
        step();
        applyStimulus(4'b0000, 1'b0);
        for (int k = 0; k < 4; k++) step();

        // Withdrawn request: req3 asks once while req1 wins, then gives up
        applyStimulus(4'b1010, 1'b0);
        checkOutput("wd_grant", {28'd0, req_ready}, 32'h2);
        expectRsp(2'd1, expRes[1]);
        step();
        applyStimulus(4'b0000, 1'b0);
        checkOutput("wd_no_grant", {28'd0, req_ready}, 32'h0);
        for (int k = 0; k < 6; k++) step();

        checkOutput("final_pending", expQueue.size(), 32'h0);
        checkOutput("final_busy", {31'd0, busy}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
